// File: rtl/dma_wr_feeder_pkg.sv
// Shared widths, sizing constants and chunk descriptor type for the AXI write-DMA feeder.
package dma_wr_feeder_pkg;

  localparam int unsigned DATA_W           = 32;
  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned BITS_TRANS       = 16;
  localparam int unsigned FIFO_DEPTH       = 512;
  localparam int unsigned CHUNK_WORDS      = 256;
  localparam int unsigned FIXED_BURST_SIZE = CHUNK_WORDS;
  localparam int unsigned BYTES_PER_WORD   = DATA_W / 8;

  typedef logic [BITS_TRANS-1:0] words_t;
  typedef logic [ADDR_W-1:0]     addr_t;

  typedef struct packed {
    addr_t  addr;
    words_t len;
  } chunk_t;

  function automatic words_t min_words(input words_t a, input words_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/dma_wr_feeder_if.sv
// Bundles the config, stream-in and DMA-side signals of the write feeder.
interface dma_wr_feeder_if;
  import dma_wr_feeder_pkg::*;

  logic              cfg_start;
  addr_t             cfg_base_addr;
  words_t            cfg_total_words;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              start_dma;
  words_t            num_trans;
  addr_t             start_addr;
  logic              indata_req;
  logic [DATA_W-1:0] indata;
  logic              data_last;
  logic              busy;
  logic              done;
  logic              err_underflow;

  modport slave (
    input  cfg_start, cfg_base_addr, cfg_total_words, in_valid, in_data,
           indata_req, data_last,
    output in_ready, start_dma, num_trans, start_addr, indata, busy, done,
           err_underflow
  );

  modport master (
    output cfg_start, cfg_base_addr, cfg_total_words, in_valid, in_data,
           indata_req, data_last,
    input  in_ready, start_dma, num_trans, start_addr, indata, busy, done,
           err_underflow
  );

endinterface

// File: rtl/dma_wr_feeder_fifo.sv
// Synchronous FIFO with a combinational head view; count is one bit wider than the pointers
// so that a completely full buffer is distinguishable from an empty one.
module dma_wr_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 512
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      push_data_i,
  input  logic                   pop_i,
  output logic [DATA_W-1:0]      head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push_s, do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == CNT_W'(0));
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = do_push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = do_pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage write port
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dma_wr_feeder.sv
// Buffers the core's word stream and issues one DMA write per chunk once that chunk
// is fully resident; serves the DMA's pull requests from the buffer head.
module dma_wr_feeder
  import dma_wr_feeder_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  dma_wr_feeder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CALC      = 3'd1,
    S_WAIT_FILL = 3'd2,
    S_RUN       = 3'd3,
    S_GAP       = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_dma_q, start_dma_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] indata_q, indata_d;
  chunk_t            chunk_q, chunk_d;
  words_t            total_q, total_d;
  words_t            remaining_q, remaining_d;
  words_t            accepted_q, accepted_d;
  words_t            len_q, len_d;
  addr_t             addr_q, addr_d;

  logic              push_s, pop_s, fill_ok_s, in_ready_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic [DATA_W-1:0] fifo_head_s;

  // Words past the job total are refused so they stay with the producer.
  assign in_ready_s = busy_q && !fifo_full_s && (accepted_q < total_q);
  assign push_s     = bus.in_valid && in_ready_s;
  assign pop_s      = bus.indata_req && !fifo_empty_s;
  assign fill_ok_s  = (words_t'(fifo_count_s) >= len_q);

  dma_wr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (push_s),
    .push_data_i (bus.in_data),
    .pop_i       (pop_s),
    .head_o      (fifo_head_s),
    .count_o     (fifo_count_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_start) begin
          state_d = (bus.cfg_total_words == words_t'(0)) ? S_DONE : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC:      state_d = S_WAIT_FILL;
      S_WAIT_FILL: state_d = fill_ok_s ? S_RUN : S_WAIT_FILL;
      S_RUN: begin
        if (bus.data_last) begin
          state_d = (remaining_q == len_q) ? S_DONE : S_GAP;
        end else begin
          state_d = S_RUN;
        end
      end
      S_GAP:   state_d = S_CALC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    busy_d      = busy_q;
    done_d      = 1'b0;
    start_dma_d = 1'b0;
    chunk_d     = chunk_q;
    total_d     = total_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    addr_d      = addr_q;
    accepted_d  = push_s ? (accepted_q + words_t'(1)) : accepted_q;
    indata_d    = pop_s ? fifo_head_s : indata_q;
    err_d       = err_q | (bus.indata_req & fifo_empty_s);
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_start) begin
          total_d     = bus.cfg_total_words;
          remaining_d = bus.cfg_total_words;
          addr_d      = bus.cfg_base_addr;
          accepted_d  = words_t'(0);
          busy_d      = 1'b1;
        end else begin
          busy_d      = busy_q;
        end
      end
      S_CALC: begin
        len_d = min_words(words_t'(FIXED_BURST_SIZE), remaining_q);
      end
      S_WAIT_FILL: begin
        if (fill_ok_s) begin
          start_dma_d = 1'b1;
          chunk_d     = '{addr: addr_q, len: len_q};
        end else begin
          start_dma_d = 1'b0;
        end
      end
      S_RUN: begin
        if (bus.data_last) begin
          addr_d      = addr_q + (addr_t'(len_q) * addr_t'(BYTES_PER_WORD));
          remaining_d = remaining_q - len_q;
        end else begin
          addr_d      = addr_q;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_dma_q <= 1'b0;
      err_q       <= 1'b0;
      indata_q    <= DATA_W'(0);
      chunk_q     <= '{addr: addr_t'(0), len: words_t'(0)};
      total_q     <= words_t'(0);
      remaining_q <= words_t'(0);
      accepted_q  <= words_t'(0);
      len_q       <= words_t'(0);
      addr_q      <= addr_t'(0);
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_dma_q <= start_dma_d;
      err_q       <= err_d;
      indata_q    <= indata_d;
      chunk_q     <= chunk_d;
      total_q     <= total_d;
      remaining_q <= remaining_d;
      accepted_q  <= accepted_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
    end
  end

  assign bus.in_ready      = in_ready_s;
  assign bus.start_dma     = start_dma_q;
  assign bus.num_trans     = chunk_q.len;
  assign bus.start_addr    = chunk_q.addr;
  assign bus.indata        = indata_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_dma_wr_feeder.sv
// Directed + randomized bench: a producer, a pull-style DMA model and a chunk-list
// reference model computed directly from job base/total.
module tb_dma_wr_feeder;
  import dma_wr_feeder_pkg::*;

  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  logic rstn;
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total_cnt = 0;
  int   push_cnt  = 0;
  bit   last_push = 1'b0;
  logic [DATA_W-1:0] words[$];
  logic [DATA_W-1:0] last_word;

  dma_wr_feeder_if bus();

  dma_wr_feeder dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Accepted-word counter (pre-edge handshake values)
  always @(posedge clk) begin
    last_push <= bus.in_valid && bus.in_ready;
    if (bus.in_valid && bus.in_ready) push_cnt <= push_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input logic [ADDR_W-1:0] base, input int total, input int vpct,
                         input bit poke, input bit exp_err);
    int exp_len[$];
    logic [ADDR_W-1:0] exp_addr[$];
    int got_len[$];
    logic [ADDR_W-1:0] got_addr[$];
    int rem, l, base_push, popped, done_cnt, word_err, fill_bad, hold_bad, cyc, resident;
    logic [ADDR_W-1:0] a;
    bit stop;
    rem = total; a = base;
    while (rem > 0) begin
      l = (rem > int'(CHUNK_WORDS)) ? int'(CHUNK_WORDS) : rem;
      exp_len.push_back(l);
      exp_addr.push_back(a);
      a = a + ADDR_W'(l * (DATA_W / 8));
      rem -= l;
    end
    words.delete();
    for (int i = 0; i < total + 8; i++) words.push_back($urandom);
    base_push = push_cnt; popped = 0; done_cnt = 0; word_err = 0;
    fill_bad = 0; hold_bad = 0; cyc = 0; resident = 0; stop = 1'b0;

    @(negedge clk);
    bus.cfg_base_addr   = base;
    bus.cfg_total_words = BITS_TRANS'(total);
    bus.cfg_start       = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    fork
      begin : producer
        int idx;
        idx = 0;
        while (!stop) begin
          bus.in_valid = (idx < words.size()) && ($urandom_range(99) < vpct);
          bus.in_data  = (idx < words.size()) ? words[idx] : DATA_W'(0);
          if (bus.in_valid && bus.in_ready) idx++;
          @(negedge clk);
        end
        bus.in_valid = 1'b0;
      end
      begin : dma_model
        int len;
        logic [ADDR_W-1:0] sa;
        while (!stop) begin
          if (bus.start_dma === 1'b1) begin
            len = int'(bus.num_trans);
            if (len > 300) len = 300;
            sa = bus.start_addr;
            got_len.push_back(len);
            got_addr.push_back(sa);
            resident = (push_cnt - int'(last_push) - base_push) - popped;
            if (resident < len) fill_bad++;
            if (poke && got_len.size() == 1) begin
              bus.cfg_base_addr   = ~base;
              bus.cfg_total_words = BITS_TRANS'(5);
              bus.cfg_start       = 1'b1;
              @(negedge clk);
              bus.cfg_start = 1'b0;
            end
            for (int k = 0; k < len; k++) begin
              repeat ($urandom_range(2)) @(negedge clk);
              bus.indata_req = 1'b1;
              @(negedge clk);
              bus.indata_req = 1'b0;
              popped++;
              if (bus.indata !== words[popped-1]) word_err++;
              if (bus.num_trans !== BITS_TRANS'(len) || bus.start_addr !== sa) hold_bad++;
            end
            bus.data_last = 1'b1;
            @(negedge clk);
            bus.data_last = 1'b0;
          end else begin
            @(negedge clk);
          end
        end
      end
      begin : watcher
        while (done_cnt == 0 && cyc < LIMIT) begin
          @(negedge clk);
          cyc++;
          if (bus.done === 1'b1) done_cnt++;
        end
        repeat (3) begin
          @(negedge clk);
          if (bus.done === 1'b1) done_cnt++;
        end
        stop = 1'b1;
      end
    join
    if (total > 0) last_word = words[total-1];

    check($sformatf("done_pulses_t%0d", total), done_cnt, 1);
    check($sformatf("chunk_count_t%0d", total), got_len.size(), exp_len.size());
    for (int i = 0; i < exp_len.size() && i < got_len.size(); i++) begin
      check($sformatf("num_trans_t%0d_c%0d", total, i), got_len[i], exp_len[i]);
      check($sformatf("start_addr_t%0d_c%0d", total, i), got_addr[i], exp_addr[i]);
    end
    check($sformatf("word_errors_t%0d", total), word_err, 0);
    check($sformatf("words_pulled_t%0d", total), popped, total);
    check($sformatf("early_start_t%0d", total), fill_bad, 0);
    check($sformatf("chunk_hold_t%0d", total), hold_bad, 0);
    check($sformatf("accepted_t%0d", total), push_cnt - base_push, total);
    check($sformatf("busy_after_t%0d", total), bus.busy, 1'b0);
    check($sformatf("in_ready_after_t%0d", total), bus.in_ready, 1'b0);
    check($sformatf("err_underflow_t%0d", total), bus.err_underflow, exp_err);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"}, bus.busy, 1'b0);
    check({pfx, "_done"}, bus.done, 1'b0);
    check({pfx, "_start_dma"}, bus.start_dma, 1'b0);
    check({pfx, "_err"}, bus.err_underflow, 1'b0);
    check({pfx, "_in_ready"}, bus.in_ready, 1'b0);
    check({pfx, "_indata"}, bus.indata, 0);
    check({pfx, "_num_trans"}, bus.num_trans, 0);
    check({pfx, "_start_addr"}, bus.start_addr, 0);
  endtask

  initial begin
    int k, cyc;
    bit seen;
    rstn = 1'b0;
    bus.cfg_start = 1'b0; bus.cfg_base_addr = '0; bus.cfg_total_words = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.indata_req = 1'b0; bus.data_last = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // T1 single chunk, T2 multi-chunk, address wrap, T3 slow producer
    run_job(32'h0000_1000, 8, 100, 1'b0, 1'b0);
    run_job(32'h2000_0000, 600, 100, 1'b0, 1'b0);
    run_job(32'hFFFF_FC00, 300, 80, 1'b0, 1'b0);
    run_job(32'h0000_4000, 16, 25, 1'b0, 1'b0);

    // T4 zero-length job
    @(negedge clk);
    bus.cfg_total_words = BITS_TRANS'(0);
    bus.cfg_base_addr   = 32'h0000_5000;
    bus.cfg_start       = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    check("t4_busy_c1", bus.busy, 1'b1);
    check("t4_done_c1", bus.done, 1'b0);
    @(negedge clk);
    check("t4_done_c2", bus.done, 1'b1);
    check("t4_busy_c2", bus.busy, 1'b0);
    check("t4_start_dma", bus.start_dma, 1'b0);
    @(negedge clk);
    check("t4_done_c3", bus.done, 1'b0);

    // T5 cfg_start while busy is ignored
    run_job(32'h0000_6000, 40, 70, 1'b1, 1'b0);

    // T5 reset mid-RUN
    @(negedge clk);
    bus.cfg_base_addr = 32'h0000_3000; bus.cfg_total_words = BITS_TRANS'(8);
    bus.cfg_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    k = 0; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      bus.in_valid = (k < 8);
      bus.in_data  = 32'h0000_A000 + k;
      if (bus.in_valid && bus.in_ready) k++;
      @(negedge clk);
      cyc++;
      if (bus.start_dma === 1'b1) seen = 1'b1;
    end
    bus.in_valid = 1'b0;
    check("t5_start_seen", seen, 1'b1);
    bus.indata_req = 1'b1;
    @(negedge clk);
    bus.indata_req = 1'b0;
    check("t5_first_word", bus.indata, 32'h0000_A000);
    #2 rstn = 1'b0;
    #1 check_all_zero("t5_midrun_reset");
    @(negedge clk);
    rstn = 1'b1;
    run_job(32'h0000_7000, 20, 60, 1'b0, 1'b0);

    // T6 underflow is sticky until reset
    @(negedge clk);
    bus.indata_req = 1'b1;
    @(negedge clk);
    bus.indata_req = 1'b0;
    check("t6_err_set", bus.err_underflow, 1'b1);
    check("t6_indata_hold", bus.indata, last_word);
    run_job(32'h0000_8000, 12, 100, 1'b0, 1'b1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("t6_err_cleared", bus.err_underflow, 1'b0);
    rstn = 1'b1;

    // Randomized jobs
    for (int j = 0; j < 3; j++) begin
      run_job($urandom & 32'hFFFF_FFFC, $urandom_range(700, 1), $urandom_range(100, 30),
              1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
